linebuf_ctrl: RTL

// Sequences two single-port-used line-buffer BRAMs (DATA_W x 2**ADDR_W, read-first, 1-cycle read latency) as a

---
 rtl/linebuf_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/linebuf_ctrl.sv
// Line-buffer sequencer for a 3x3 median: cascades two read-first BRAMs into a 2-line delay and emits
// aligned (y-2, y-1, y) columns with coordinates. Fixed 3-cycle latency, no backpressure.
module linebuf_ctrl #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_width,
  input  logic [ROW_W-1:0]  line_height,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] ram0_addr,
  output logic              ram0_we,
  output logic [DATA_W-1:0] ram0_din,
  input  logic [DATA_W-1:0] ram0_dout,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_we,
  output logic [DATA_W-1:0] ram1_din,
  input  logic [DATA_W-1:0] ram1_dout,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_top,
  output logic [DATA_W-1:0] win_mid,
  output logic [DATA_W-1:0] win_bot,
  output logic [ADDR_W-1:0] win_x,
  output logic [ROW_W-1:0]  win_y,
  output logic              win_sol,
  output logic              win_eol,
  output logic              frame_done,
  output logic              cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d, w_q, w_d;
  logic [ROW_W-1:0]  row_q, row_d, h_q, h_d;

  logic              sof_hit, size_ok, start, reject, accept, cur_eol, cur_last;
  logic [ADDR_W-1:0] cur_col, cur_w;
  logic [ROW_W-1:0]  cur_row, cur_h;

  // stage 1: BRAM0 read in flight; stage 2: BRAM1 read in flight
  logic              s1_vld_q, s1_eol_q, s1_last_q;
  logic [ADDR_W-1:0] s1_col_q;
  logic [ROW_W-1:0]  s1_row_q;
  logic [DATA_W-1:0] s1_bot_q;
  logic              s2_vld_q, s2_eol_q, s2_last_q, s2_emit;
  logic [ADDR_W-1:0] s2_col_q;
  logic [ROW_W-1:0]  s2_row_q;
  logic [DATA_W-1:0] s2_bot_q, s2_mid_q;

  logic              win_valid_q, win_sol_q, win_eol_q, frame_done_q, cfg_err_q;
  logic [DATA_W-1:0] win_top_q, win_mid_q, win_bot_q;
  logic [ADDR_W-1:0] win_x_q;
  logic [ROW_W-1:0]  win_y_q;

  always_comb begin
    sof_hit  = in_valid && in_sof && !rst;
    size_ok  = (line_width >= ADDR_W'(3)) && (line_height >= ROW_W'(3));
    start    = sof_hit && size_ok;
    reject   = sof_hit && !size_ok;
    accept   = start || (in_valid && !in_sof && !rst && (state_q == RUN));
    // an accepted SOF restarts at (0,0) with freshly sampled sizes
    cur_col  = start ? '0 : col_q;
    cur_row  = start ? '0 : row_q;
    cur_w    = start ? line_width : w_q;
    cur_h    = start ? line_height : h_q;
    cur_eol  = (cur_col == cur_w - ADDR_W'(1));
    cur_last = cur_eol && (cur_row == cur_h - ROW_W'(1));

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    if (reject) begin
      state_d = IDLE;
    end
    if (accept) begin
      w_d = cur_w;
      h_d = cur_h;
      if (cur_last) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = RUN;
        if (cur_eol) begin
          col_d = '0;
          row_d = cur_row + ROW_W'(1);
        end else begin
          col_d = cur_col + ADDR_W'(1);
          row_d = cur_row;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
    end
  end

  // rows 0/1 of a frame only prime the line buffers
  assign s2_emit = s2_vld_q && (s2_row_q >= ROW_W'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_eol_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_bot_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_eol_q     <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_col_q     <= '0;
      s2_row_q     <= '0;
      s2_bot_q     <= '0;
      s2_mid_q     <= '0;
      win_valid_q  <= 1'b0;
      win_sol_q    <= 1'b0;
      win_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      win_top_q    <= '0;
      win_mid_q    <= '0;
      win_bot_q    <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      s1_vld_q     <= accept;
      s1_eol_q     <= cur_eol;
      s1_last_q    <= accept && cur_last;
      s1_col_q     <= cur_col;
      s1_row_q     <= cur_row;
      s1_bot_q     <= in_data;
      s2_vld_q     <= s1_vld_q;
      s2_eol_q     <= s1_eol_q;
      s2_last_q    <= s1_last_q;
      s2_col_q     <= s1_col_q;
      s2_row_q     <= s1_row_q;
      s2_bot_q     <= s1_bot_q;
      s2_mid_q     <= ram0_dout;
      win_valid_q  <= s2_emit;
      win_sol_q    <= s2_emit && (s2_col_q == '0);
      win_eol_q    <= s2_emit && s2_eol_q;
      frame_done_q <= s2_emit && s2_last_q;
      cfg_err_q    <= reject;
      win_top_q    <= ram1_dout;
      win_mid_q    <= s2_mid_q;
      win_bot_q    <= s2_bot_q;
      win_x_q      <= s2_col_q;
      win_y_q      <= s2_row_q;
    end
  end

  assign ram0_addr  = accept ? cur_col : '0;
  assign ram0_we    = accept;
  assign ram0_din   = in_data;
  assign ram1_addr  = s1_col_q;
  assign ram1_we    = s1_vld_q;
  assign ram1_din   = ram0_dout;
  assign win_valid  = win_valid_q;
  assign win_top    = win_top_q;
  assign win_mid    = win_mid_q;
  assign win_bot    = win_bot_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign win_sol    = win_sol_q;
  assign win_eol    = win_eol_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule
